multi_edge_detector: RTL and testbench
======================================

# multi_edge_detector

Parametrised multi-channel edge detector with an input synchroniser, glitch filter, per-channel edge-mode select and sticky event flags. It takes raw, possibly asynchronous, 1-bit signals such as buttons, sensor strobes or handshake lines. For each channel it produces a clean filtered level, a one-cycle edge pulse and a software-clearable sticky flag. It sits between board-level inputs and the control FSMs and interrupt logic.

## Interface
- CH, 4: number of independent channels (≥1).
- SYNC_STAGES, 2: synchroniser flip-flop depth per channel (≥2).
- FILT_CYC, 4: consecutive cycles a synchronised value must differ from the filtered level before the filtered level changes (≥1; 1 = no filtering).

Ports:
- i_clk  input  1  single system clock; all logic is on its rising edge.
- i_rst  input  1  reset, asynchronous and active-high; clears every register.
- i_sig  input  CH  raw input per channel, asynchronous to i_clk.
- i_mode  input  2*CH  per-channel mode, bits [2k+1:2k] for channel k: 00 off, 01 rising, 10 falling, 11 both.
- i_clr  input  CH  write-1-to-clear for o_sticky, one bit per channel.
- o_level  output  CH  filtered, synchronised level.
- o_pulse  output  CH  registered one-cycle pulse on each qualifying edge.
- o_sticky  output  CH  set by o_pulse and held until cleared.
- o_any  output  1  OR of all o_sticky bits (combinational from registers).

## Operation
Synchroniser:
- Each channel has a SYNC_STAGES-deep flip-flop chain.
- sync_out is the last stage of the chain.

Filter, per channel (two states, tracked by o_level):
- The counter cnt is $clog2(FILT_CYC+1) bits wide.
- While sync_out == o_level: cnt is held at 0.
- While sync_out != o_level: cnt increments each cycle.
- When cnt reaches FILT_CYC-1 and a mismatch is still present, o_level toggles on that edge and cnt returns to 0.
- A mismatch lasting fewer than FILT_CYC cycles resets cnt and leaves o_level unchanged (glitch rejected).
- The counter never wraps, because it is cleared on reaching its terminal count.

Edge pulse:
- o_pulse[k] is registered.
- It is high for exactly one cycle, on the same edge at which o_level[k] toggles, qualified by the mode:
  - rising: only a 0→1 toggle pulses.
  - falling: only a 1→0 toggle pulses.
  - both: either toggle pulses.
  - off: no pulse; o_level still tracks the input.
- The mode is sampled on the edge at which the toggle occurs. A mode change therefore takes effect from the next edge, with no extra pipeline.

Sticky flags:
- o_sticky[k] is set on any edge where the pulse condition is true.
- o_sticky[k] is cleared on any edge where i_clr[k] = 1 and no set condition is present.
- Simultaneous set and clear: set wins and the flag stays 1.
- Clearing an already-clear flag has no effect.

Channels are fully independent; events on different channels in the same cycle are all reported.

## Timing
Reset values: sync chains, cnt, o_level, o_pulse and o_sticky are all 0, so o_any = 0.

Reset mid-operation: all state clears immediately and in-flight pulses are lost.

Reset with an input held high: o_level starts at 0. After reset release, a high input is treated as a rising transition and pulses if the mode allows it. This is intended, so that software sees lines that were already asserted.

Latency, for i_sig[k] settling before edge E0 and held stable:
- o_level[k] and o_pulse[k] change at edge E0 + SYNC_STAGES + FILT_CYC − 1.
- With defaults this is E0 + 5.
- o_sticky[k] sets on that same edge.

Pulse spacing:
- Minimum spacing between two pulses on one channel is FILT_CYC cycles.
- There is no back-to-back pulse unless FILT_CYC = 1 and the input toggles every cycle after synchronisation.

i_clr acts on the clock edge at which it is sampled high; o_sticky drops on the following cycle.

No handshake and no backpressure: pulses are fire-and-forget, and the sticky flags hold events for slower consumers.

## Test plan
1. Reset and defaults (CH=4, SYNC_STAGES=2, FILT_CYC=4): hold i_rst=1 with i_sig=4'hF → all outputs 0. Release reset with i_mode all 01 → o_level=4'hF and o_pulse=4'hF for one cycle, 5 cycles after release; o_sticky=4'hF; o_any=1.
2. Glitch rejection: ch0 in mode 11; drive i_sig[0] high for 3 cycles then low → o_level[0] stays 0, no pulse. Drive high for 4 cycles → o_level[0] rises, one pulse at E0+5.
3. Mode qualification: drive ch1 rise then fall, 20 cycles apart, once under each mode 00, 01, 10 and 11 → pulse count is 0, 1 (rise), 1 (fall) and 2 respectively. o_level[1] toggles in all four modes.
4. Sticky clear collision: assert i_clr[2]=1 on the exact edge ch2 pulses → o_sticky[2] stays 1. Assert i_clr[2] one cycle later → o_sticky[2]=0 and o_any falls if no other flag is set.
5. Reset mid-filter: assert i_rst when cnt[3]=2 → everything clears at once. After release the count restarts from 0 and the full latency applies.
6. Multi-channel simultaneity: toggle all channels in the same cycle with random modes → each pulse matches its own mode on the same edge; compare against a reference model over 10k random cycles with FILT_CYC=1 and FILT_CYC=7.

Source files
------------

// File: rtl/multi_edge_detector.sv
// multi_edge_detector
//
// Multi-channel edge detector for raw, possibly asynchronous 1-bit inputs.
// Each channel passes through a synchroniser chain and a persistence
// filter. The filter produces a clean level, a registered one-cycle edge
// pulse qualified by a per-channel mode, and a write-1-to-clear sticky flag.
//
// Parameters:
//   CH          - number of independent channels (>= 1)
//   SYNC_STAGES - synchroniser depth per channel (>= 2)
//   FILT_CYC    - consecutive mismatching cycles needed before the filtered
//                 level follows the synchronised input (>= 1, 1 = no filter)
//
// Ports:
//   i_clk    - system clock, rising edge
//   i_rst    - asynchronous active-high reset, clears every register
//   i_sig    - raw input per channel, asynchronous to i_clk
//   i_mode   - per-channel mode in bits [2k+1:2k]:
//              00 off, 01 rising, 10 falling, 11 both
//   i_clr    - write-1-to-clear for o_sticky, one bit per channel
//   o_level  - filtered, synchronised level
//   o_pulse  - registered one-cycle pulse on each qualifying edge
//   o_sticky - set by a qualifying edge, held until cleared
//   o_any    - OR of all sticky flags

module multi_edge_detector #(
  parameter int unsigned CH          = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_CYC    = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [CH-1:0]   i_sig,
  input  logic [2*CH-1:0] i_mode,
  input  logic [CH-1:0]   i_clr,
  output logic [CH-1:0]   o_level,
  output logic [CH-1:0]   o_pulse,
  output logic [CH-1:0]   o_sticky,
  output logic            o_any
);

  // Counter is wide enough to hold FILT_CYC-1; it is cleared on reaching that
  // terminal value, so it never wraps.
  localparam int unsigned     CntW    = $clog2(FILT_CYC + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FILT_CYC - 1);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  // ---------------------------------------------------------------------------
  // Synchroniser: stage 0 samples the raw input, the last stage feeds the filter
  // ---------------------------------------------------------------------------
  logic [CH-1:0] sync_q [SYNC_STAGES];
  logic [CH-1:0] sync_out;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= i_sig;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Persistence filter, edge qualification and sticky flags
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] cnt_q [CH];
  logic [CntW-1:0] cnt_d [CH];
  logic [CH-1:0]   level_q, level_d;
  logic [CH-1:0]   pulse_q, pulse_d;
  logic [CH-1:0]   sticky_q, sticky_d;
  logic [CH-1:0]   mismatch;
  logic [CH-1:0]   toggle;

  always_comb begin
    mismatch = '0;
    toggle   = '0;
    level_d  = level_q;
    pulse_d  = '0;
    sticky_d = sticky_q;
    for (int k = 0; k < int'(CH); k++) begin
      cnt_d[k] = '0;
    end

    for (int k = 0; k < int'(CH); k++) begin
      mismatch[k] = sync_out[k] ^ level_q[k];
      // Toggle on the FILT_CYC-th consecutive mismatching cycle.
      toggle[k]   = mismatch[k] && (cnt_q[k] == CntLast);

      if (mismatch[k] && !toggle[k]) begin
        cnt_d[k] = cnt_q[k] + CntOne;
      end else begin
        cnt_d[k] = '0;
      end

      level_d[k] = level_q[k] ^ toggle[k];

      // Mode bit 0 enables rising (level currently 0), bit 1 enables falling.
      // The mode is taken live on the toggling edge.
      pulse_d[k] = toggle[k] &&
                   ((!level_q[k] && i_mode[2*k]) || (level_q[k] && i_mode[2*k+1]));

      // Set has priority over a simultaneous clear.
      if (pulse_d[k]) begin
        sticky_d[k] = 1'b1;
      end else if (i_clr[k]) begin
        sticky_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < int'(CH); k++) begin
        cnt_q[k] <= '0;
      end
      level_q  <= '0;
      pulse_q  <= '0;
      sticky_q <= '0;
    end else begin
      for (int k = 0; k < int'(CH); k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      level_q  <= level_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
    end
  end

  assign o_level  = level_q;
  assign o_pulse  = pulse_q;
  assign o_sticky = sticky_q;
  assign o_any    = |sticky_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector: three instances (FILT_CYC = 4, 1, 7) share
// one stimulus stream and are compared every cycle against a window-based
// reference model, with literal expectations for the directed scenarios.

module tb_multi_edge_detector;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int NI   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sig = 4'h0;
  logic [7:0] mode = 8'h00;
  logic [3:0] clr = 4'h0;

  logic [3:0] lvl_a [NI];
  logic [3:0] pul_a [NI];
  logic [3:0] stk_a [NI];
  logic       any_a [NI];

  int checks   = 0;
  int failures = 0;
  int pc1      = 0;
  int pc0      = 0;
  int filt [NI];

  // Reference model state
  logic [3:0] raw_hist [$];
  logic [3:0] syn_hist [$];
  logic [3:0] m_lvl [NI];
  logic [3:0] m_pul [NI];
  logic [3:0] m_stk [NI];

  always #5 clk = ~clk;

  multi_edge_detector #(.CH(CH), .SYNC_STAGES(SYNC), .FILT_CYC(4)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_sig(sig), .i_mode(mode), .i_clr(clr),
    .o_level(lvl_a[0]), .o_pulse(pul_a[0]), .o_sticky(stk_a[0]), .o_any(any_a[0])
  );

  multi_edge_detector #(.CH(CH), .SYNC_STAGES(SYNC), .FILT_CYC(1)) u_f1 (
    .i_clk(clk), .i_rst(rst), .i_sig(sig), .i_mode(mode), .i_clr(clr),
    .o_level(lvl_a[1]), .o_pulse(pul_a[1]), .o_sticky(stk_a[1]), .o_any(any_a[1])
  );

  multi_edge_detector #(.CH(CH), .SYNC_STAGES(SYNC), .FILT_CYC(7)) u_f7 (
    .i_clk(clk), .i_rst(rst), .i_sig(sig), .i_mode(mode), .i_clr(clr),
    .o_level(lvl_a[2]), .o_pulse(pul_a[2]), .o_sticky(stk_a[2]), .o_any(any_a[2])
  );

  task automatic chk(input string name, input int inst, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t got=%h want=%h", name, inst, $time, act, exp);
    end
  endtask

  // Model: the filter sees the input as sampled SYNC edges earlier; the level
  // flips once the last F synchronised samples all differ from it.
  task automatic model_edge();
    logic [3:0] used;
    logic       all_diff;
    logic       p;
    if (rst) begin
      raw_hist.delete();
      syn_hist.delete();
      for (int i = 0; i < NI; i++) begin
        m_lvl[i] = '0;
        m_pul[i] = '0;
        m_stk[i] = '0;
      end
    end else begin
      used = '0;
      raw_hist.push_back(sig);
      if (raw_hist.size() > SYNC) used = raw_hist.pop_front();
      syn_hist.push_back(used);
      if (syn_hist.size() > 8) void'(syn_hist.pop_front());
      for (int i = 0; i < NI; i++) begin
        for (int k = 0; k < CH; k++) begin
          all_diff = (syn_hist.size() >= filt[i]);
          for (int j = 0; j < filt[i]; j++) begin
            if (all_diff && syn_hist[syn_hist.size() - 1 - j][k] == m_lvl[i][k]) all_diff = 1'b0;
          end
          p = all_diff && (m_lvl[i][k] ? mode[2*k+1] : mode[2*k]);
          if (all_diff) m_lvl[i][k] = ~m_lvl[i][k];
          m_pul[i][k] = p;
          if (p) m_stk[i][k] = 1'b1;
          else if (clr[k]) m_stk[i][k] = 1'b0;
        end
      end
    end
  endtask

  // One clock: update the model on the edge, then compare every instance.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("level", i, lvl_a[i], m_lvl[i]);
      chk("pulse", i, pul_a[i], m_pul[i]);
      chk("sticky", i, stk_a[i], m_stk[i]);
      chk("any", i, {3'b000, any_a[i]}, {3'b000, |m_stk[i]});
    end
    if (pul_a[0][1]) pc1++;
    if (pul_a[0][0]) pc0++;
  endtask

  task automatic wait_pulse(input int bit_k, input int expect_n, input string name);
    int n;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (pul_a[0][bit_k]) begin
        n = c;
        break;
      end
    end
    chk(name, 0, 4'(n), 4'(expect_n));
  endtask

  initial begin
    filt[0] = 4;
    filt[1] = 1;
    filt[2] = 7;

    // 1. Reset with inputs high, then release in rising mode.
    rst  = 1'b1;
    sig  = 4'hF;
    mode = 8'h55;
    repeat (3) step();
    chk("rst_level", 0, lvl_a[0], 4'h0);
    chk("rst_pulse", 0, pul_a[0], 4'h0);
    chk("rst_sticky", 0, stk_a[0], 4'h0);
    chk("rst_any", 0, {3'b000, any_a[0]}, 4'h0);
    rst = 1'b0;
    repeat (5) step();
    chk("pre_latency_level", 0, lvl_a[0], 4'h0);
    step();
    chk("latency_level", 0, lvl_a[0], 4'hF);
    chk("latency_pulse", 0, pul_a[0], 4'hF);
    step();
    chk("pulse_one_cycle", 0, pul_a[0], 4'h0);
    chk("post_sticky", 0, stk_a[0], 4'hF);
    chk("post_any", 0, {3'b000, any_a[0]}, 4'h1);

    // 2. Glitch rejection on ch0.
    mode = 8'hFF;
    sig  = 4'h0;
    clr  = 4'hF;
    repeat (12) step();
    clr = 4'h0;
    pc0 = 0;
    sig[0] = 1'b1;
    repeat (3) step();
    sig[0] = 1'b0;
    repeat (10) step();
    chk("glitch_level", 0, {3'b000, lvl_a[0][0]}, 4'h0);
    chk("glitch_pulses", 0, 4'(pc0), 4'h0);
    sig[0] = 1'b1;
    wait_pulse(0, 6, "glitch_pass_latency");
    chk("glitch_pass_level", 0, {3'b000, lvl_a[0][0]}, 4'h1);

    // 3. Mode qualification on ch1.
    for (int m = 0; m < 4; m++) begin
      logic [3:0] exp_cnt [4];
      exp_cnt[0] = 4'd0;
      exp_cnt[1] = 4'd1;
      exp_cnt[2] = 4'd1;
      exp_cnt[3] = 4'd2;
      mode[3:2] = 2'(m);
      pc1 = 0;
      sig[1] = 1'b1;
      repeat (20) step();
      chk("mode_rise_level", m, {3'b000, lvl_a[0][1]}, 4'h1);
      sig[1] = 1'b0;
      repeat (20) step();
      chk("mode_fall_level", m, {3'b000, lvl_a[0][1]}, 4'h0);
      chk("mode_pulse_count", m, 4'(pc1), exp_cnt[m]);
    end

    // 4. Clear colliding with set on ch2, then a plain clear.
    mode = 8'hFF;
    clr  = 4'hF;
    repeat (2) step();
    clr = 4'h0;
    sig[2] = 1'b1;
    repeat (5) step();
    clr = 4'b0100;
    step();
    chk("collide_pulse", 0, {3'b000, pul_a[0][2]}, 4'h1);
    chk("collide_sticky", 0, {3'b000, stk_a[0][2]}, 4'h1);
    step();
    chk("clear_sticky", 0, {3'b000, stk_a[0][2]}, 4'h0);
    chk("clear_any", 0, {3'b000, any_a[0]}, 4'h0);
    clr = 4'h0;

    // 5. Reset while ch3 is mid-filter.
    mode = 8'h55;
    sig[3] = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("midrst_level", 0, lvl_a[0], 4'h0);
    chk("midrst_pulse", 0, pul_a[0], 4'h0);
    chk("midrst_sticky", 0, stk_a[0], 4'h0);
    rst = 1'b0;
    wait_pulse(3, 6, "midrst_latency");

    // 6. Random traffic, all channels, random modes, clears and rare resets.
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) sig = 4'($urandom);
      else if ($urandom_range(0, 3) == 0) sig[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 1999) == 0) rst = 1'b1;
      else rst = 1'b0;
      step();
    end
    rst = 1'b0;
    clr = 4'h0;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
